apb_mailbox_slave: RTL

// APB completer (slave) end of the bus driven by the project's APB master. Accepts

---
 rtl/apb_mailbox_slave_if.sv | 39 +++
 rtl/apb_mailbox_slave.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/apb_mailbox_slave_if.sv
// apb_mailbox_slave_if
// Bundles the APB completer signals and the FIFO drain handshake of apb_mailbox_slave.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB request from the master
//   PRDATA/PREADY[/PSLVERR]           : APB response from the slave
//   m_valid/m_data/m_ready            : FIFO head towards the local consumer
// Build macro: APB_SLVERR_EN adds PSLVERR.
interface apb_mailbox_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
`ifdef APB_SLVERR_EN
    logic        PSLVERR;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, m_ready,
        output PRDATA, PREADY, PSLVERR, m_valid, m_data
    );
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, m_ready,
        input  PRDATA, PREADY, PSLVERR, m_valid, m_data
    );
`else
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, m_ready,
        output PRDATA, PREADY, m_valid, m_data
    );
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, m_ready,
        input  PRDATA, PREADY, m_valid, m_data
    );
`endif
endinterface

// File: rtl/apb_mailbox_slave.sv
// apb_mailbox_slave
// APB completer with four word registers fronting a write FIFO drained by a
// valid/ready consumer. PREADY is delayed by a programmable number of wait states.
//   PCLK    : clock, rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : apb_mailbox_slave_if.slave (APB request/response + FIFO head handshake)
// Register map (PADDR[3:2]): 0 DATA (W push), 1 STATUS (R), 2 CTRL (ws[7:4], flush[0]),
// 3 SCRATCH.
// Build macro: APB_SLVERR_EN enables the PSLVERR error response.
module apb_mailbox_slave #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_mailbox_slave_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [3:0]    ws_q;
    logic [31:0]   scratch_q;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic        setup, pready, wr_cmt;
    logic        empty, full, pop, push, flush;
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic        unused_paddr;

    assign addr         = bus.PADDR[3:2];
    assign unused_paddr = ^{bus.PADDR[31:4], bus.PADDR[1:0]};
    assign setup        = bus.PSEL & ~bus.PENABLE;

    // FSM: state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d = StAccess;
                    wait_d  = ws_q;
                end
            end
            StAccess: begin
                if (!bus.PSEL) begin
                    state_d = StIdle;           // abandoned transfer
                end else if (setup) begin
                    wait_d = ws_q;              // fresh SETUP restarts the wait
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d = StIdle;           // committing edge
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        pready = 1'b0;
        if (state_q == StAccess && bus.PSEL && bus.PENABLE && wait_q == 4'd0) begin
            pready = 1'b1;
        end
    end

    assign wr_cmt = pready & bus.PWRITE;
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign pop    = ~empty & bus.m_ready;
    assign flush  = wr_cmt & (addr == 2'd2) & bus.PWDATA[0];
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push   = wr_cmt & (addr == 2'd0) & (~full | pop);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr_q] <= bus.PWDATA;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ws_q      <= 4'(WAIT_STATES);
            scratch_q <= '0;
        end else if (wr_cmt) begin
            if (addr == 2'd2) ws_q      <= bus.PWDATA[7:4];
            if (addr == 2'd3) scratch_q <= bus.PWDATA;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd1: begin
                rdata[0]    = empty;
                rdata[1]    = full;
                rdata[15:8] = 8'(count_q);
            end
            2'd2:    rdata[7:4] = ws_q;
            2'd3:    rdata = scratch_q;
            default: rdata = '0;
        endcase
    end

    assign bus.PREADY  = pready;
    assign bus.PRDATA  = pready ? rdata : 32'd0;
    assign bus.m_valid = ~empty;
    assign bus.m_data  = empty ? 32'd0 : mem[rd_ptr_q];

`ifdef APB_SLVERR_EN
    assign bus.PSLVERR = pready & ((~bus.PWRITE & (addr == 2'd0)) |
                                   (bus.PWRITE & (addr == 2'd1)) |
                                   (bus.PWRITE & (addr == 2'd0) & full & ~pop));
`endif
endmodule
